// File: rtl/serial_word_rx_if.sv
// Bit-serial input and valid/ready word output bundle for serial_word_rx.
// slave modport is the receiver side; master is the stream source / word consumer side.
interface serial_word_rx_if #(
  parameter int W = 4
);
  logic         s_valid;
  logic         s_bit;
  logic         s_first;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_err;
  logic         overrun;

  modport slave (
    input  s_valid, s_bit, s_first, m_ready,
    output m_valid, m_data, m_err, overrun
  );

  modport master (
    output s_valid, s_bit, s_first, m_ready,
    input  m_valid, m_data, m_err, overrun
  );
endinterface

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver with one word of valid/ready output storage.
// Optional trailing even-parity bit per frame when RX_PARITY_EN is defined.
module serial_word_rx #(
  parameter int W         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  serial_word_rx_if.slave bus
);
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef RX_PARITY_EN
    ST_PAR  = 2'd2,
`endif
    ST_DATA = 2'd1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    shift_q, shift_d;
  logic            m_valid_q, m_valid_d;
  logic [W-1:0]    m_data_q, m_data_d;
  logic            m_err_q, m_err_d;
  logic            overrun_q, overrun_d;

  logic            done;
  logic [W-1:0]    done_word;
  logic            done_err;
  logic [W-1:0]    shift_in;
  logic [W-1:0]    shift_first;

  // Shifting toward the far end places frame bit k at W-1-k (MSB first) or k (LSB first).
  always_comb begin
    if (MSB_FIRST) begin
      shift_in    = {shift_q[W-2:0], bus.s_bit};
      shift_first = {{(W-1){1'b0}}, bus.s_bit};
    end else begin
      shift_in    = {bus.s_bit, shift_q[W-1:1]};
      shift_first = {bus.s_bit, {(W-1){1'b0}}};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_err_d   = m_err_q;
    overrun_d = 1'b0;
    done      = 1'b0;
    done_word = shift_q;
    done_err  = 1'b0;

    if (m_valid_q && bus.m_ready) m_valid_d = 1'b0;

    if (bus.s_valid) begin
      if (bus.s_first) begin
        shift_d = shift_first;
        cnt_d   = CNT_ONE;
        state_d = ST_DATA;
      end else begin
        case (state_q)
          ST_DATA: begin
            shift_d = shift_in;
            cnt_d   = (cnt_q == CNT_FULL) ? CNT_FULL : cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
`ifdef RX_PARITY_EN
              state_d = ST_PAR;
`else
              state_d   = ST_IDLE;
              cnt_d     = '0;
              done      = 1'b1;
              done_word = shift_in;
`endif
            end
          end
`ifdef RX_PARITY_EN
          ST_PAR: begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            done      = 1'b1;
            done_word = shift_q;
            done_err  = bus.s_bit ^ (^shift_q);
          end
`endif
          default: ;
        endcase
      end
    end

    // A word may land in the same cycle the previous one is being taken.
    if (done) begin
      if (!m_valid_q || bus.m_ready) begin
        m_valid_d = 1'b1;
        m_data_d  = done_word;
        m_err_d   = done_err;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_err_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_err_q   <= m_err_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_err   = m_err_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_serial_word_rx.sv
// Scoreboard bench for serial_word_rx: one MSB-first and one LSB-first instance share the stream.
module tb_serial_word_rx;
  localparam int W = 4;
`ifdef RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic s_bit = 1'b0;
  logic s_first = 1'b0;
  logic m_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int ovr_cnt_m = 0;
  int ovr_cnt_l = 0;
  exp_t q_m[$];
  exp_t q_l[$];

  serial_word_rx_if #(.W(W)) if_m ();
  serial_word_rx_if #(.W(W)) if_l ();

  assign if_m.s_valid = s_valid;
  assign if_m.s_bit   = s_bit;
  assign if_m.s_first = s_first;
  assign if_m.m_ready = m_ready;
  assign if_l.s_valid = s_valid;
  assign if_l.s_bit   = s_bit;
  assign if_l.s_first = s_first;
  assign if_l.m_ready = m_ready;

  serial_word_rx #(.W(W), .MSB_FIRST(1'b1)) u_dut_m (.clk(clk), .rst(rst), .bus(if_m.slave));
  serial_word_rx #(.W(W), .MSB_FIRST(1'b0)) u_dut_l (.clk(clk), .rst(rst), .bus(if_l.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic drive_bit(input logic b, input logic first);
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_bit   = b;
    s_first = first;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_first = 1'b0;
  endtask

  // word is written in frame order: frame bit k is word[W-1-k].
  task automatic send_frame(input logic [W-1:0] word, input logic bad_par, input bit push);
    exp_t e;
    for (int k = 0; k < W; k++) drive_bit(word[W-1-k], (k == 0));
    if (PAR_EN) drive_bit((^word) ^ bad_par, 1'b0);
    if (push) begin
      e.err  = PAR_EN ? bad_par : 1'b0;
      e.data = word;
      q_m.push_back(e);
      e.data = rev(word);
      q_l.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (if_m.m_valid && m_ready) begin
        if (q_m.size() == 0) chk("unexpected_word_m", 32'(if_m.m_data), 32'hdead);
        else begin
          e = q_m.pop_front();
          chk("data_m", 32'(if_m.m_data), 32'(e.data));
          chk("err_m", 32'(if_m.m_err), 32'(e.err));
        end
      end
      if (if_l.m_valid && m_ready) begin
        if (q_l.size() == 0) chk("unexpected_word_l", 32'(if_l.m_data), 32'hdead);
        else begin
          e = q_l.pop_front();
          chk("data_l", 32'(if_l.m_data), 32'(e.data));
          chk("err_l", 32'(if_l.m_err), 32'(e.err));
        end
      end
      if (if_m.overrun) ovr_cnt_m++;
      if (if_l.overrun) ovr_cnt_l++;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid_m"}, 32'(if_m.m_valid), 32'd0);
    chk({tag, "_data_m"}, 32'(if_m.m_data), 32'd0);
    chk({tag, "_err_m"}, 32'(if_m.m_err), 32'd0);
    chk({tag, "_ovr_m"}, 32'(if_m.overrun), 32'd0);
    chk({tag, "_valid_l"}, 32'(if_l.m_valid), 32'd0);
    chk({tag, "_data_l"}, 32'(if_l.m_data), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk);
    #1 rst = 1'b0;

    // basic frame 1,1,0,0 with consumer ready, one-cycle valid pulse
    m_ready = 1'b1;
    send_frame(4'b1100, 1'b0, 1'b1);
    idle_cycle();
    @(negedge clk);
    chk("latency_valid", 32'(if_m.m_valid), 32'd1);
    @(negedge clk);
    chk("pulse_len", 32'(if_m.m_valid), 32'd0);

    // parity good then bad, same data
    send_frame(4'b1010, 1'b0, 1'b1);
    send_frame(4'b1010, 1'b1, 1'b1);
    idle_cycle();
    repeat (2) idle_cycle();

    // back-to-back random frames
    for (int i = 0; i < 6; i++)
      send_frame(W'($urandom_range(0, (1 << W) - 1)), 1'($urandom_range(0, 1)), 1'b1);
    repeat (3) idle_cycle();

    // overrun: consumer stalled, second frame dropped
    m_ready = 1'b0;
    send_frame(4'b1010, 1'b0, 1'b1);
    send_frame(4'b0110, 1'b0, 1'b0);
    idle_cycle();
    @(negedge clk);
    chk("ovr_pulse_m", 32'(if_m.overrun), 32'd1);
    chk("ovr_pulse_l", 32'(if_l.overrun), 32'd1);
    chk("ovr_hold_data_m", 32'(if_m.m_data), 32'b1010);
    chk("ovr_hold_data_l", 32'(if_l.m_data), 32'b0101);
    chk("ovr_hold_valid", 32'(if_m.m_valid), 32'd1);
    @(negedge clk);
    chk("ovr_one_cycle", 32'(if_m.overrun), 32'd0);
    chk("stall_data_m", 32'(if_m.m_data), 32'b1010);
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("drain_valid", 32'(if_m.m_valid), 32'd0);

    // restart mid-frame: aborted 1,1 then 0111
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b0);
    send_frame(4'b0111, 1'b0, 1'b1);
    repeat (3) idle_cycle();
    @(negedge clk);
    chk("restart_data_m", 32'(if_m.m_data), 32'b0111);

    // reset mid-frame, then a clean frame
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_valid = 1'b0;
    s_first = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    send_frame(4'b1001, 1'b0, 1'b1);
    repeat (3) idle_cycle();
    @(negedge clk);
    chk("post_rst_data_m", 32'(if_m.m_data), 32'b1001);
    chk("post_rst_data_l", 32'(if_l.m_data), 32'b1001);

    repeat (4) idle_cycle();
    chk("q_m_empty", 32'(q_m.size()), 32'd0);
    chk("q_l_empty", 32'(q_l.size()), 32'd0);
    chk("ovr_count_m", 32'(ovr_cnt_m), 32'd1);
    chk("ovr_count_l", 32'(ovr_cnt_l), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel word receiver: collects a framed, bit-serial stream and reassembles it into a W-bit parallel word, with the bit order set by a parameter. It sits on the receive side of the design's serial word link and is the consuming end of the bit-serial word transmitter. The assembled word is presented on a valid/ready output port with one word of output storage.

## Interface
- W, default 4: data word width in bits, 2..32.
- MSB_FIRST, default 1:
  - 1: the first received bit lands in m_data[W-1] (descending order).
  - 0: the first received bit lands in m_data[0] (ascending order).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  a serial bit is present this cycle.
- s_bit  in  1  the serial bit; sampled only when s_valid=1.
- s_first  in  1  qualifies the current bit as bit 0 of a new frame; sampled only when s_valid=1.
- m_valid  out  1  m_data holds an unconsumed word.
- m_ready  in  1  consumer accepts the word when m_valid & m_ready.
- m_data  out  W  assembled word.
- m_err  out  1  parity error flag for the word in m_data; valid when m_valid=1.
- overrun  out  1  one-cycle pulse: a completed frame was dropped because the output was full.

## Operation
- State machine: IDLE, DATA, PAR. PAR exists only with RX_PARITY_EN.
- Serial input has no backpressure; a bit is consumed on every cycle with s_valid=1.
- IDLE:
  - s_valid & s_first: store the bit at position 0, set bit count to 1, go to DATA.
  - s_valid & !s_first: ignore the bit.
- DATA, accepting a bit with s_first=0:
  - Store the bit at the next position and increment the count.
  - Position k of the frame maps to m_data[W-1-k] when MSB_FIRST=1, and to m_data[k] when MSB_FIRST=0.
  - When the count reaches W: go to PAR if parity is enabled, otherwise complete the frame and return to IDLE.
- DATA or PAR, accepting a bit with s_first=1: abort the current partial frame with no output, and restart it with this bit as bit 0.
- PAR, accepting a bit with s_first=0: compare the bit against the even parity (XOR) of the W data bits, complete the frame, return to IDLE.
- Frame completion:
  - Output empty, or being emptied this same cycle (m_valid & m_ready): load m_data and m_err, set m_valid.
  - Otherwise: drop the word, pulse overrun, leave m_data, m_err and m_valid unchanged.
- A handshake with no completion in the same cycle clears m_valid. m_data keeps its last value.
- Shift and assembly register: W bits. Bit count: $clog2(W+1) bits, saturating at W, never wrapping.
- Reset, including mid-frame: state=IDLE, count=0, partial frame discarded.

## Timing
- Reset values:
  - m_valid=0, m_data=0, m_err=0, overrun=0, state=IDLE.
  - The assembly register is also cleared.
- Latency: m_valid=1 and the new m_data appear in the cycle after the edge that accepts the last bit of the frame (the last data bit, or the parity bit when enabled).
- Back-to-back frames: a new frame may start the cycle after the previous frame's last bit. Minimum frame period is W cycles, or W+1 with parity.
- overrun is high for exactly the cycle following the dropped completion.
- m_data, m_err and m_valid are stable while m_valid=1 and m_ready=0.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- RX_PARITY_EN defined:
  - Each frame carries one extra trailing even-parity bit, so frame length is W+1.
  - PAR state is present.
  - m_err = (received parity != XOR of data bits).
- RX_PARITY_EN undefined:
  - Frame length is W and PAR state is absent.
  - m_err is constant 0.

## Test plan
- W=4, MSB_FIRST=1, no parity. Bits 1,1,0,0 with s_first on the first bit, m_ready=1 → m_data=4'b1100, m_valid high for 1 cycle, starting the cycle after bit 3.
- W=4, MSB_FIRST=0, same bits 1,1,0,0 → m_data=4'b0011.
- RX_PARITY_EN, W=4, MSB_FIRST=1:
  - Bits 1,0,1,0 then parity 0 → m_data=4'b1010, m_err=0.
  - Same data with parity 1 → m_err=1.
- Overrun: m_ready=0, two back-to-back frames 1010 then 0110 → m_data stays 4'b1010; overrun pulses 1 cycle after the second frame's last bit. Raising m_ready then clears m_valid.
- Restart: bits 1,1 then s_first with bits 0,1,1,1 → single word 4'b0111 (MSB_FIRST=1); no word for the aborted frame.
- Assert rst after 2 bits of a frame, then release rst and send a full frame 1001 → outputs at reset values during rst; output after release is exactly 4'b1001.
